fht_job_scheduler: RTL and testbench

//  Shares one FHT core (4-bank RAM + stage controller) between two requester channels.

---
 rtl/fht_job_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_fht_job_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_job_scheduler.sv
// Shares one FHT core between two channels: round-robin grant, load, start, run, unload, done per job.
// All outputs registered; oUL_VALID trails oUL_RD by RD_LAT cycles; watchdog traps a stuck core.
module fht_job_scheduler #(
    parameter int A_BIT   = 8,
    parameter int RD_LAT  = 2,
    parameter int TMO_BIT = 12
) (
    input  logic             iCLK_2,
    input  logic             iRESET,
    input  logic [1:0]       iREQ,
    output logic [1:0]       oGNT,
    input  logic             iLD_VALID,
    output logic             oLD_WE,
    output logic [1:0]       oLD_BANK,
    output logic [A_BIT-1:0] oLD_ADDR,
    output logic             oFHT_START,
    input  logic             iFHT_RDY,
    output logic [A_BIT-1:0] oUL_ADDR,
    output logic             oUL_RD,
    output logic             oUL_VALID,
    output logic [1:0]       oDONE,
    output logic             oERR,
    output logic             oBUSY
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOAD    = 4'd1;
    localparam logic [3:0] S_START   = 4'd2;
    localparam logic [3:0] S_WAIT_LO = 4'd3;
    localparam logic [3:0] S_RUN     = 4'd4;
    localparam logic [3:0] S_UNLOAD  = 4'd5;
    localparam logic [3:0] S_DRAIN   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    localparam logic [A_BIT+1:0]   LD_LAST = '1;
    localparam logic [A_BIT-1:0]   UL_LAST = '1;
    localparam logic [TMO_BIT-1:0] WD_LAST = '1;
    // Only the final read is still in flight when the valid pipe holds this pattern.
    localparam logic [RD_LAT-1:0]  SR_LAST = RD_LAT'(1) << (RD_LAT - 1);

    logic [3:0]         state_q,   state_d;
    logic               rr_q,      rr_d;
    logic [1:0]         gnt_q,     gnt_d;
    logic [A_BIT+1:0]   k_q,       k_d;
    logic               ld_we_q,   ld_we_d;
    logic [1:0]         ld_bank_q, ld_bank_d;
    logic [A_BIT-1:0]   ld_addr_q, ld_addr_d;
    logic               start_q,   start_d;
    logic [TMO_BIT-1:0] wd_q,      wd_d;
    logic [A_BIT-1:0]   ul_addr_q, ul_addr_d;
    logic               ul_rd_q,   ul_rd_d;
    logic [RD_LAT-1:0]  sr_q,      sr_d;
    logic [1:0]         done_q,    done_d;
    logic               err_q,     err_d;
    logic               busy_q,    busy_d;

    generate
        if (RD_LAT == 1) begin : g_sr1
            assign sr_d = ul_rd_q;
        end else begin : g_srn
            assign sr_d = {sr_q[RD_LAT-2:0], ul_rd_q};
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        k_d       = k_q;
        ld_we_d   = 1'b0;
        ld_bank_d = ld_bank_q;
        ld_addr_d = ld_addr_q;
        start_d   = 1'b0;
        wd_d      = '0;
        ul_addr_d = ul_addr_q;
        ul_rd_d   = 1'b0;
        done_d    = 2'b00;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (iREQ != 2'b00) begin
                    if (iREQ[0] && (!iREQ[1] || !rr_q)) begin
                        gnt_d = 2'b01;
                        rr_d  = 1'b1;
                    end else begin
                        gnt_d = 2'b10;
                        rr_d  = 1'b0;
                    end
                    k_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (iLD_VALID) begin
                    ld_we_d   = 1'b1;
                    ld_bank_d = k_q[1:0];
                    ld_addr_d = k_q[A_BIT+1:2];
                    k_d       = k_q + 1'b1;
                    if (k_q == LD_LAST) begin
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: state_d = S_WAIT_LO;
            S_WAIT_LO, S_RUN: begin
                // Watchdog spans both wait phases; a ready level seen first in RUN still completes.
                wd_d = wd_q + 1'b1;
                if (state_q == S_WAIT_LO && !iFHT_RDY) begin
                    state_d = S_RUN;
                end else if (state_q == S_RUN && iFHT_RDY) begin
                    ul_rd_d   = 1'b1;
                    ul_addr_d = '0;
                    state_d   = S_UNLOAD;
                end else if (wd_d == WD_LAST) begin
                    gnt_d   = 2'b00;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_UNLOAD: begin
                ul_addr_d = ul_addr_q + 1'b1;
                if (ul_addr_q == UL_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    ul_rd_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (sr_q == SR_LAST) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   gnt_d   = 2'b00;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iCLK_2 or negedge iRESET) begin
        if (!iRESET) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            gnt_q     <= 2'b00;
            k_q       <= '0;
            ld_we_q   <= 1'b0;
            ld_bank_q <= 2'b00;
            ld_addr_q <= '0;
            start_q   <= 1'b0;
            wd_q      <= '0;
            ul_addr_q <= '0;
            ul_rd_q   <= 1'b0;
            sr_q      <= '0;
            done_q    <= 2'b00;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            k_q       <= k_d;
            ld_we_q   <= ld_we_d;
            ld_bank_q <= ld_bank_d;
            ld_addr_q <= ld_addr_d;
            start_q   <= start_d;
            wd_q      <= wd_d;
            ul_addr_q <= ul_addr_d;
            ul_rd_q   <= ul_rd_d;
            sr_q      <= sr_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign oGNT       = gnt_q;
    assign oLD_WE     = ld_we_q;
    assign oLD_BANK   = ld_bank_q;
    assign oLD_ADDR   = ld_addr_q;
    assign oFHT_START = start_q;
    assign oUL_ADDR   = ul_addr_q;
    assign oUL_RD     = ul_rd_q;
    assign oUL_VALID  = sr_q[RD_LAT-1];
    assign oDONE      = done_q;
    assign oERR       = err_q;
    assign oBUSY      = busy_q;

endmodule

// File: tb/tb_fht_job_scheduler.sv
// Randomized bench for fht_job_scheduler with an FHT core stand-in and a job-level reference model.
`timescale 1ns/1ps
module tb_fht_job_scheduler;

    localparam int A_BIT   = 8;
    localparam int RD_LAT  = 2;
    localparam int TMO_BIT = 12;
    localparam int N_WORDS = 4 * (1 << A_BIT);
    localparam int N_UL    = 1 << A_BIT;
    localparam int TMO     = (1 << TMO_BIT) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       iREQ;
    logic [1:0]       oGNT;
    logic             iLD_VALID;
    logic             oLD_WE;
    logic [1:0]       oLD_BANK;
    logic [A_BIT-1:0] oLD_ADDR;
    logic             oFHT_START;
    logic             iFHT_RDY;
    logic [A_BIT-1:0] oUL_ADDR;
    logic             oUL_RD;
    logic             oUL_VALID;
    logic [1:0]       oDONE;
    logic             oERR;
    logic             oBUSY;
    logic [2*A_BIT+11:0] all_out;

    always #5 clk = ~clk;

    fht_job_scheduler #(.A_BIT(A_BIT), .RD_LAT(RD_LAT), .TMO_BIT(TMO_BIT)) dut (
        .iCLK_2(clk), .iRESET(rst_n), .iREQ(iREQ), .oGNT(oGNT), .iLD_VALID(iLD_VALID),
        .oLD_WE(oLD_WE), .oLD_BANK(oLD_BANK), .oLD_ADDR(oLD_ADDR), .oFHT_START(oFHT_START),
        .iFHT_RDY(iFHT_RDY), .oUL_ADDR(oUL_ADDR), .oUL_RD(oUL_RD), .oUL_VALID(oUL_VALID),
        .oDONE(oDONE), .oERR(oERR), .oBUSY(oBUSY)
    );

    assign all_out = {oGNT, oLD_WE, oLD_BANK, oLD_ADDR, oFHT_START, oUL_ADDR, oUL_RD,
                      oUL_VALID, oDONE, oERR, oBUSY};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ld_seen, ld_bad, starts, start_cyc, ul_seen, ul_bad, vld_seen;
    int last_rd_cyc, last_vld_cyc, dones, done_cyc, err_cyc;
    bit core_stuck = 1'b0;
    int run_len    = 2600;
    int rr_pref    = 0;

    // Reference view of the word stream: word i lands in bank i%4 at address i/4.
    always @(negedge clk) begin
        cyc++;
        if (oLD_WE) begin
            if (oLD_BANK !== 2'(ld_seen % 4) || oLD_ADDR !== A_BIT'(ld_seen / 4)) ld_bad++;
            ld_seen++;
        end
        if (oFHT_START) begin starts++; start_cyc = cyc; end
        if (oUL_RD) begin
            if (oUL_ADDR !== A_BIT'(ul_seen)) ul_bad++;
            ul_seen++;
            last_rd_cyc = cyc;
        end
        if (oUL_VALID) begin vld_seen++; last_vld_cyc = cyc; end
        if (oDONE != 2'b00) begin dones++; done_cyc = cyc; end
        if (oERR && err_cyc < 0) err_cyc = cyc;
    end

    // Core stand-in: goes busy 3 cycles after a start and stays busy run_len cycles.
    initial begin
        iFHT_RDY = 1'b1;
        forever begin
            @(negedge clk);
            if (oFHT_START && !core_stuck) begin
                repeat (3) @(posedge clk);
                #1; iFHT_RDY = 1'b0;
                repeat (run_len) @(posedge clk);
                #1; iFHT_RDY = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: run still active at cycle %0d, required to finish", cyc);
        $fatal(1, "simulation time limit");
    end

    function automatic logic [1:0] model_grant(input logic [1:0] req);
        if (req == 2'b11) return (rr_pref == 0) ? 2'b01 : 2'b10;
        return req;
    endfunction

    task automatic clear_mon();
        ld_seen = 0; ld_bad = 0; starts = 0; start_cyc = -1; ul_seen = 0; ul_bad = 0;
        vld_seen = 0; last_rd_cyc = -1; last_vld_cyc = -1; dones = 0; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic do_reset();
        #1; rst_n = 1'b0; iREQ = 2'b00; iLD_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        rr_pref = 0;
        clear_mon();
    endtask

    // gap_mode: 0 back-to-back words, 1 random 0..2 idle cycles, 2 one word every third cycle.
    task automatic run_job(input logic [1:0] req, input logic [1:0] req_after, input int gap_mode,
                           input bit drop, input bit wait_done, output logic [1:0] gnt_seen,
                           output logic [1:0] done_seen, output bit tmo);
        int gaps;
        tmo = 1'b0; gnt_seen = 2'b00; done_seen = 2'b00;
        clear_mon();
        iREQ = req;
        for (int i = 0; i < 50 && oGNT == 2'b00; i++) @(negedge clk);
        if (oGNT == 2'b00) begin tmo = 1'b1; return; end
        gnt_seen = oGNT;
        @(posedge clk); #1;
        if (drop) iREQ = 2'b00;
        for (int w = 0; w < N_WORDS; w++) begin
            gaps = (gap_mode == 1) ? int'($urandom_range(2, 0)) : (gap_mode == 2) ? 2 : 0;
            iLD_VALID = 1'b0;
            repeat (gaps) begin @(posedge clk); #1; end
            iLD_VALID = 1'b1;
            @(posedge clk); #1;
        end
        iLD_VALID = 1'b0;
        if (!wait_done) return;
        for (int i = 0; i < 20000 && done_seen == 2'b00; i++) begin
            @(negedge clk);
            done_seen = oDONE;
        end
        if (done_seen == 2'b00) tmo = 1'b1;
        @(posedge clk); #1;
        iREQ = req_after;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iREQ = 2'b00; iLD_VALID = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %0h want 0", all_out); end
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (oBUSY !== 1'b0 || oGNT !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_req: busy=%0b gnt=%0b want 0/00", oBUSY, oGNT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_job();
        logic [1:0] g, d, exp_g;
        bit tmo;
        run_len = 2600;
        exp_g = model_grant(2'b01);
        run_job(2'b01, 2'b00, 0, 1'b0, 1'b1, g, d, tmo);
        rr_pref = (exp_g == 2'b01) ? 1 : 0;
        n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL single_tmo: timed out=%0b want 0", tmo); end
        n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL single_gnt: got %b want %b", g, exp_g); end
        n_checks++; if (ld_seen !== N_WORDS) begin n_fail++; $display("FAIL single_ld_cnt: got %0d want %0d", ld_seen, N_WORDS); end
        n_checks++; if (ld_bad !== 0) begin n_fail++; $display("FAIL single_ld_addr: %0d bad words, want 0", ld_bad); end
        n_checks++; if (starts !== 1) begin n_fail++; $display("FAIL single_start: got %0d pulses want 1", starts); end
        n_checks++; if (ul_seen !== N_UL || ul_bad !== 0) begin
            n_fail++; $display("FAIL single_ul: reads=%0d bad=%0d want %0d/0", ul_seen, ul_bad, N_UL);
        end
        n_checks++; if (vld_seen !== N_UL) begin n_fail++; $display("FAIL single_vld_cnt: got %0d want %0d", vld_seen, N_UL); end
        n_checks++; if (last_vld_cyc - last_rd_cyc !== RD_LAT) begin
            n_fail++; $display("FAIL single_rd_lat: got %0d want %0d", last_vld_cyc - last_rd_cyc, RD_LAT);
        end
        n_checks++; if (done_cyc - last_vld_cyc !== 1) begin
            n_fail++; $display("FAIL single_done_lat: got %0d want 1", done_cyc - last_vld_cyc);
        end
        n_checks++; if (d !== exp_g || dones !== 1) begin
            n_fail++; $display("FAIL single_done: got %b x%0d want %b x1", d, dones, exp_g);
        end
        @(negedge clk);
        n_checks++; if (oBUSY !== 1'b0 || oGNT !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: busy=%0b gnt=%b want 0/00", oBUSY, oGNT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_simultaneous();
        logic [1:0] g, d, exp_g, after;
        bit tmo;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            run_len = $urandom_range(400, 100);
            exp_g = model_grant(2'b11);
            after = (j < 2) ? 2'b11 : 2'b00;
            run_job(2'b11, after, 1, 1'b0, 1'b1, g, d, tmo);
            rr_pref = (exp_g == 2'b01) ? 1 : 0;
            n_checks++; if (g !== exp_g || tmo) begin
                n_fail++; $display("FAIL tie_gnt_%0d: got %b tmo=%0b want %b", j, g, tmo, exp_g);
            end
            n_checks++; if (d !== exp_g || ld_seen !== N_WORDS || ld_bad !== 0) begin
                n_fail++; $display("FAIL tie_job_%0d: done=%b words=%0d bad=%0d want %b/%0d/0", j, d, ld_seen, ld_bad, exp_g, N_WORDS);
            end
        end
    endtask

    task automatic test_load_gaps();
        logic [1:0] g, d, req, exp_g;
        bit tmo;
        req = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
        run_len = $urandom_range(300, 50);
        exp_g = model_grant(req);
        run_job(req, 2'b00, 2, 1'b0, 1'b1, g, d, tmo);
        rr_pref = (exp_g == 2'b01) ? 1 : 0;
        n_checks++; if (ld_seen !== N_WORDS || ld_bad !== 0) begin
            n_fail++; $display("FAIL gaps_load: words=%0d bad=%0d want %0d/0", ld_seen, ld_bad, N_WORDS);
        end
        n_checks++; if (g !== exp_g || d !== exp_g || tmo) begin
            n_fail++; $display("FAIL gaps_job: gnt=%b done=%b tmo=%0b want %b", g, d, tmo, exp_g);
        end
        n_checks++; if (ul_seen !== N_UL || ul_bad !== 0 || vld_seen !== N_UL) begin
            n_fail++; $display("FAIL gaps_unload: reads=%0d bad=%0d vld=%0d want %0d/0/%0d", ul_seen, ul_bad, vld_seen, N_UL, N_UL);
        end
    endtask

    task automatic test_req_drop();
        logic [1:0] g, d, exp_g;
        bit tmo;
        run_len = $urandom_range(300, 50);
        exp_g = model_grant(2'b10);
        run_job(2'b10, 2'b00, 1, 1'b1, 1'b1, g, d, tmo);
        rr_pref = (exp_g == 2'b01) ? 1 : 0;
        n_checks++; if (d !== exp_g || tmo || ul_seen !== N_UL) begin
            n_fail++; $display("FAIL drop_job: done=%b tmo=%0b reads=%0d want %b/0/%0d", d, tmo, ul_seen, exp_g, N_UL);
        end
    endtask

    task automatic test_watchdog();
        logic [1:0] g, d;
        bit tmo;
        int delta;
        do_reset();
        core_stuck = 1'b1;
        run_job(2'b01, 2'b00, 0, 1'b0, 1'b0, g, d, tmo);
        for (int i = 0; i < 6000 && err_cyc < 0; i++) @(negedge clk);
        delta = err_cyc - start_cyc;
        n_checks++; if (err_cyc < 0 || start_cyc < 0 || delta < TMO || delta > TMO + 2) begin
            n_fail++; $display("FAIL wdog_time: start->err=%0d cycles (err_cyc=%0d) want %0d..%0d", delta, err_cyc, TMO, TMO + 2);
        end
        n_checks++; if (oERR !== 1'b1 || oGNT !== 2'b00 || oBUSY !== 1'b1) begin
            n_fail++; $display("FAIL wdog_state: err=%0b gnt=%b busy=%0b want 1/00/1", oERR, oGNT, oBUSY);
        end
        iREQ = 2'b00;
        repeat (30) @(negedge clk);
        n_checks++; if (oERR !== 1'b1 || dones !== 0) begin
            n_fail++; $display("FAIL wdog_sticky: err=%0b dones=%0d want 1/0", oERR, dones);
        end
        #1; rst_n = 1'b0;
        #1;
        n_checks++; if (oERR !== 1'b0) begin n_fail++; $display("FAIL wdog_clear: err=%0b want 0", oERR); end
        core_stuck = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; rr_pref = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_unload();
        logic [1:0] g, d;
        bit tmo;
        bit found;
        run_len = $urandom_range(300, 50);
        run_job(2'b01, 2'b00, 1, 1'b0, 1'b0, g, d, tmo);
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            found = (oUL_RD === 1'b1 && oUL_ADDR === A_BIT'(100));
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL mid_reach: unload addr 100 seen=%0b want 1", found); end
        #1; rst_n = 1'b0; iREQ = 2'b00;
        #1;
        n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL mid_reset_now: got %0h want 0", all_out); end
        clear_mon();
        @(negedge clk);
        n_checks++; if (all_out !== '0) begin n_fail++; $display("FAIL mid_reset_next: got %0h want 0", all_out); end
        @(posedge clk); #1; rst_n = 1'b1; rr_pref = 0;
        repeat (10) @(negedge clk);
        n_checks++; if (starts !== 0 || dones !== 0 || oBUSY !== 1'b0) begin
            n_fail++; $display("FAIL mid_quiet: starts=%0d dones=%0d busy=%0b want 0/0/0", starts, dones, oBUSY);
        end
        @(posedge clk); #1;
        run_job(2'b10, 2'b00, 1, 1'b0, 1'b1, g, d, tmo);
        rr_pref = 0;
        n_checks++; if (g !== 2'b10 || d !== 2'b10 || tmo || ul_seen !== N_UL || vld_seen !== N_UL) begin
            n_fail++; $display("FAIL mid_rejob: gnt=%b done=%b tmo=%0b reads=%0d vld=%0d want 10/10/0/%0d/%0d", g, d, tmo, ul_seen, vld_seen, N_UL, N_UL);
        end
    endtask

    task automatic test_random();
        logic [1:0] g, d, req, exp_g;
        bit tmo;
        for (int j = 0; j < 4; j++) begin
            req = 2'($urandom_range(3, 1));
            run_len = $urandom_range(500, 20);
            exp_g = model_grant(req);
            run_job(req, 2'b00, 1, 1'b0, 1'b1, g, d, tmo);
            rr_pref = (exp_g == 2'b01) ? 1 : 0;
            n_checks++; if (g !== exp_g || d !== exp_g || tmo || starts !== 1) begin
                n_fail++; $display("FAIL rand_job_%0d: req=%b gnt=%b done=%b tmo=%0b starts=%0d want %b/%b/0/1", j, req, g, d, tmo, starts, exp_g, exp_g);
            end
        end
    endtask

    initial begin
        iREQ = 2'b00; iLD_VALID = 1'b0; rst_n = 1'b0;
        test_reset();
        test_single_job();
        test_simultaneous();
        test_load_gaps();
        test_req_drop();
        test_watchdog();
        test_reset_mid_unload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
